// File: rtl/alu_share_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_pkg
// Shared types and constants for the ALU sharing arbiter.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package alu_share_pkg;

  // Operation lifecycle: no op held, ALU evaluating, result waiting for consumer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Width of the instr[31:12] field carried with each operation
  localparam int INSTR_W   = 20;

  // Largest supported requester count
  localparam int N_REQ_MAX = 4;

endpackage

`default_nettype wire

// File: rtl/alu_share_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: first set request at or above ptr, with
// wrap-around. Returns a one-hot grant, its binary index and an any flag.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import alu_share_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             any_o
);

  // Doubling the request vector lets a plain right shift act as a rotation,
  // so bit k of rot is request (ptr + k) mod N_REQ.
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W:0]      sum;

  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[N_REQ-1:0];

  // Priority-encode the rotated vector and map the offset back to an index
  always_comb begin
    gnt_id_o = '0;
    any_o    = 1'b0;
    sum      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        sum   = {1'b0, ptr_i} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_REQ)) begin
          sum = sum - (ID_W+1)'(N_REQ);
        end
        gnt_id_o = sum[ID_W-1:0];
      end
    end
  end

  assign gnt_o = any_o ? (N_REQ'(1) << gnt_id_o) : '0;

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Time-shares one external combinational ALU between N_REQ requesters with a
// round-robin grant, registered operands and a per-requester response.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*XLEN-1:0]  req_x1_i,
  input  logic [N_REQ*XLEN-1:0]  req_x2_i,
  input  logic [N_REQ*INSTR_W-1:0] req_instr_i,
  input  logic [N_REQ-1:0]       req_op4_i,
  input  logic [N_REQ-1:0]       req_cin_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  input  logic [N_REQ-1:0]       rsp_ready_i,
  output logic [XLEN-1:0]        rsp_y_o,
  output logic                   rsp_cout_o,
  output logic [XLEN-1:0]        alu_x1_o,
  output logic [XLEN-1:0]        alu_x2_o,
  output logic [INSTR_W-1:0]     alu_instr_o,
  output logic                   alu_op4_o,
  output logic                   alu_cin_o,
  input  logic [XLEN-1:0]        alu_y_i,
  input  logic                   alu_cout_i
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e               state_q;
  logic [ID_W-1:0]      gnt_id_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [ID_W-1:0]      rr_ptr_d;
  logic [N_REQ-1:0]     rsp_valid_q;
  logic [XLEN-1:0]      rsp_y_q;
  logic                 rsp_cout_q;
  logic [XLEN-1:0]      alu_x1_q;
  logic [XLEN-1:0]      alu_x2_q;
  logic [INSTR_W-1:0]   alu_instr_q;
  logic                 alu_op4_q;
  logic                 alu_cin_q;

  logic [N_REQ-1:0]     pick_gnt;
  logic [ID_W-1:0]      pick_id;
  logic                 pick_any;

  logic [XLEN-1:0]      sel_x1;
  logic [XLEN-1:0]      sel_x2;
  logic [INSTR_W-1:0]   sel_instr;
  logic                 sel_op4;
  logic                 sel_cin;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (pick_gnt),
    .gnt_id_o (pick_id),
    .any_o    (pick_any)
  );

  // Payload of the requester the picker currently favours (one-hot mux)
  always_comb begin
    sel_x1    = '0;
    sel_x2    = '0;
    sel_instr = '0;
    sel_op4   = 1'b0;
    sel_cin   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_x1    = req_x1_i[i*XLEN +: XLEN];
        sel_x2    = req_x2_i[i*XLEN +: XLEN];
        sel_instr = req_instr_i[i*INSTR_W +: INSTR_W];
        sel_op4   = req_op4_i[i];
        sel_cin   = req_cin_i[i];
      end
    end
  end

  // Pointer moves just past the requester whose response completes
  assign rr_ptr_d = (gnt_id_q == ID_W'(N_REQ-1)) ? '0 : gnt_id_q + ID_W'(1);

  // Accepts happen only while idle; the picker already limits this to one bit
  assign req_ready_o = (state_q == IDLE) ? pick_gnt : '0;

  // Operation FSM with operand, result and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      rsp_cout_q  <= 1'b0;
      alu_x1_q    <= '0;
      alu_x2_q    <= '0;
      alu_instr_q <= '0;
      alu_op4_q   <= 1'b0;
      alu_cin_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            alu_x1_q    <= sel_x1;
            alu_x2_q    <= sel_x2;
            alu_instr_q <= sel_instr;
            alu_op4_q   <= sel_op4;
            alu_cin_q   <= sel_cin;
            gnt_id_q    <= pick_id;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_q     <= alu_y_i;
          rsp_cout_q  <= alu_cout_i;
          rsp_valid_q <= N_REQ'(1) << gnt_id_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i[gnt_id_q]) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_y_o     = rsp_y_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign alu_x1_o    = alu_x1_q;
  assign alu_x2_o    = alu_x2_q;
  assign alu_instr_o = alu_instr_q;
  assign alu_op4_o   = alu_op4_q;
  assign alu_cin_o   = alu_cin_q;

endmodule

`default_nettype wire
